// File: rtl/msrv32_pkg.sv
// Shared msrv32 types and default widths for the integer register file.
// Optional macro MSRV32_RF_BYPASS_EN is consumed by msrv32_rf_read_port.
package msrv32_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  localparam int MSRV32_XLEN  = 32;
  localparam int MSRV32_NREGS = 32;

endpackage

// File: rtl/msrv32_integer_file_mp_if.sv
// Decode/writeback side bundle of the multi-port integer register file.
// Decode and writeback drive the master side; the file is the slave.
interface msrv32_integer_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [NRD*ADDR_W-1:0] rs_addr_in;
  logic [NRD*XLEN-1:0]   rs_out;
  logic [NRD-1:0]        rs_pend_out;
  logic                  wr_en_in;
  logic [ADDR_W-1:0]     rd_addr_in;
  logic [XLEN-1:0]       rd_in;
  logic                  pend_set_in;
  logic [ADDR_W-1:0]     pend_addr_in;
  logic                  ready_out;

  modport master (
    output rs_addr_in, wr_en_in, rd_addr_in, rd_in,
    output pend_set_in, pend_addr_in,
    input  rs_out, rs_pend_out, ready_out
  );

  modport slave (
    input  rs_addr_in, wr_en_in, rd_addr_in, rd_in,
    input  pend_set_in, pend_addr_in,
    output rs_out, rs_pend_out, ready_out
  );
endinterface

// File: rtl/msrv32_rf_read_port.sv
// One combinational read port: x0 zeroing, optional bypass, pending lookup.
// Bypass of same-cycle writeback is built when MSRV32_RF_BYPASS_EN is defined.
module msrv32_rf_read_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  ready,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [NREGS*XLEN-1:0] mem_flat,
  input  logic [NREGS-1:0]      pending,
  input  logic                  wr_hit,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  set_hit,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic [XLEN-1:0]       data,
  output logic                  pend
);

  logic            live;
  logic [XLEN-1:0] stored;

  assign live   = ready && (addr != '0);
  assign stored = mem_flat[int'(addr)*XLEN +: XLEN];

`ifdef MSRV32_RF_BYPASS_EN
  logic byp;
  logic keep_pend;

  assign byp       = wr_hit && (wr_addr == addr);
  // a same-cycle pend set on this address overrides the write's clear
  assign keep_pend = set_hit && (set_addr == addr);

  always_comb begin
    data = '0;
    pend = 1'b0;
    if (live) begin
      data = byp ? wr_data : stored;
      pend = (byp && !keep_pend) ? 1'b0 : pending[addr];
    end
  end
`else
  logic unused_byp;

  assign unused_byp = ^{wr_hit, wr_addr, wr_data,
                        set_hit, set_addr};

  always_comb begin
    data = '0;
    pend = 1'b0;
    if (live) begin
      data = stored;
      pend = pending[addr];
    end
  end
`endif

endmodule

// File: rtl/msrv32_integer_file_mp.sv
// Multi-port msrv32 integer register file with post-reset clear and pending bits.
// Same-cycle write bypass on read ports is enabled by MSRV32_RF_BYPASS_EN.
module msrv32_integer_file_mp
  import msrv32_pkg::*;
#(
  parameter int XLEN  = MSRV32_XLEN,
  parameter int NREGS = MSRV32_NREGS,
  parameter int NRD   = 2
) (
  input logic ms_riscv32_mp_clk_in,
  input logic ms_riscv32_mp_rst_in,
  msrv32_integer_file_mp_if.slave bus
);

  localparam int ADDR_W = $clog2(NREGS);

  rf_state_t             state;
  logic [ADDR_W-1:0]     clr_cnt;
  logic [XLEN-1:0]       mem [NREGS];
  logic [NREGS*XLEN-1:0] mem_flat;
  logic [NREGS-1:0]      pending;
  logic                  ready;
  logic                  wr_hit;
  logic                  set_hit;

  assign ready   = (state == RF_READY);
  assign wr_hit  = ready && bus.wr_en_in
                 && (bus.rd_addr_in != '0);
  assign set_hit = ready && bus.pend_set_in
                 && (bus.pend_addr_in != '0);

  assign bus.ready_out = ready;

  always_ff @(posedge ms_riscv32_mp_clk_in or
              posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state   <= RF_CLEAR;
      clr_cnt <= ADDR_W'(1);
      pending <= '0;
    end else if (state == RF_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (clr_cnt == ADDR_W'(NREGS - 1))
        state <= RF_READY;
    end else begin
      // set is applied last so it wins over a same-address write
      if (wr_hit)
        pending[bus.rd_addr_in] <= 1'b0;
      if (set_hit)
        pending[bus.pend_addr_in] <= 1'b1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (state == RF_CLEAR)
      mem[clr_cnt] <= '0;
    else if (wr_hit)
      mem[bus.rd_addr_in] <= bus.rd_in;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign mem_flat[g*XLEN +: XLEN] = mem[g];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    msrv32_rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_port (
      .ready    (ready),
      .addr     (bus.rs_addr_in[k*ADDR_W +: ADDR_W]),
      .mem_flat (mem_flat),
      .pending  (pending),
      .wr_hit   (wr_hit),
      .wr_addr  (bus.rd_addr_in),
      .wr_data  (bus.rd_in),
      .set_hit  (set_hit),
      .set_addr (bus.pend_addr_in),
      .data     (bus.rs_out[k*XLEN +: XLEN]),
      .pend     (bus.rs_pend_out[k])
    );
  end

endmodule

// File: tb/tb_msrv32_integer_file_mp.sv
// Bench for msrv32_integer_file_mp: default 2-port build plus a 4-port/16-reg build.
// Expectations follow MSRV32_RF_BYPASS_EN when it is defined.
module tb_msrv32_integer_file_mp;

`ifdef MSRV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        ps;
    logic [4:0]  pa;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ep0;
    logic        ep1;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        p0;
    logic        p1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  vec_t tv[12];

  always #5 clk = ~clk;

  msrv32_integer_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) b0 ();
  msrv32_integer_file_mp_if #(.XLEN(32), .NREGS(16), .NRD(4)) b1 ();

  msrv32_integer_file_mp #(.XLEN(32), .NREGS(32), .NRD(2)) u0 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (b0.slave)
  );

  msrv32_integer_file_mp #(.XLEN(32), .NREGS(16), .NRD(4)) u1 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (b1.slave)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive0(logic wr, logic [4:0] ra, logic [31:0] rd,
                        logic ps, logic [4:0] pa,
                        logic [4:0] a0, logic [4:0] a1);
    b0.wr_en_in     = wr;
    b0.rd_addr_in   = ra;
    b0.rd_in        = rd;
    b0.pend_set_in  = ps;
    b0.pend_addr_in = pa;
    b0.rs_addr_in   = {a1, a0};
  endtask

  // drive one cycle's inputs, queue the expectation, sample before the edge
  task automatic step0(string nm, logic wr, logic [4:0] ra,
                       logic [31:0] rd, logic ps, logic [4:0] pa,
                       logic [4:0] a0, logic [4:0] a1,
                       logic [31:0] e0, logic [31:0] e1,
                       logic ep0, logic ep1);
    exp_t e;
    drive0(wr, ra, rd, ps, pa, a0, a1);
    sbq.push_back('{e0, e1, ep0, ep1});
    #1;
    e = sbq.pop_front();
    chk({nm, ".d0"}, b0.rs_out[31:0], e.d0);
    chk({nm, ".d1"}, b0.rs_out[63:32], e.d1);
    chk({nm, ".p0"}, {31'd0, b0.rs_pend_out[0]}, {31'd0, e.p0});
    chk({nm, ".p1"}, {31'd0, b0.rs_pend_out[1]}, {31'd0, e.p1});
  endtask

  // release reset between edges and count edges until each file is ready
  task automatic release_and_count(string nm);
    int n;
    int n1;
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    n1 = 0;
    while (!b0.ready_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (b1.ready_out && n1 == 0) n1 = n;
      if (n == 5) chk({nm, ".clr_rd"}, b0.rs_out[31:0], 32'd0);
    end
    chk({nm, ".edges32"}, n, 31);
    chk({nm, ".edges16"}, n1, 15);
  endtask

  initial begin
    tv[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2,
               32'h0, 32'h0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd5,
               32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd5,
               32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
               32'h0, 32'h0, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 5'd9, 32'h11112222, 1'b0, 5'd0, 5'd5, 5'd6,
               32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
               32'h11112222, 32'h11112222, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 5'd9, 32'h33334444, 1'b1, 5'd9, 5'd5, 5'd1,
               32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
               32'h33334444, 32'h0, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 5'd10, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 5'd0,
               32'h0, 32'h0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd10, 5'd9,
               32'hCAFEF00D, 32'h33334444, 1'b0, 1'b1};
    tv[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
               32'h00000033, 32'h0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 5'd7, 32'h00000011, 1'b0, 5'd0, 5'd3, 5'd9,
               32'h00000033, 32'h33334444, 1'b0, 1'b1};

    drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    b1.wr_en_in = 1'b0;
    b1.rd_addr_in = '0;
    b1.rd_in = '0;
    b1.pend_set_in = 1'b0;
    b1.pend_addr_in = '0;
    b1.rs_addr_in = '0;

    #12;
    chk("rst.ready", {31'd0, b0.ready_out}, 32'd0);
    chk("rst.rs0", b0.rs_out[31:0], 32'd0);
    chk("rst.rs1", b0.rs_out[63:32], 32'd0);
    chk("rst.pend", {30'd0, b0.rs_pend_out}, 32'd0);
    chk("rst.ready16", {31'd0, b1.ready_out}, 32'd0);

    release_and_count("boot");

    for (int a = 0; a < 32; a++) begin
      b0.rs_addr_in = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("zero.p0.x%0d", a), b0.rs_out[31:0], 32'd0);
      chk($sformatf("zero.p1.x%0d", 31 - a), b0.rs_out[63:32], 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      step0($sformatf("tv%0d", i), tv[i].wr, tv[i].ra, tv[i].rd,
            tv[i].ps, tv[i].pa, tv[i].a0, tv[i].a1,
            tv[i].e0, tv[i].e1, tv[i].ep0, tv[i].ep1);
    end

    // same-cycle write visibility on x7 (holds 0x11) and x9 (holds 0x33334444, pending)
    @(posedge clk);
    #1;
    step0("byp7", 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd9,
          BYP ? 32'hA5A5A5A5 : 32'h00000011, 32'h33334444, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    step0("byp9", 1'b1, 5'd9, 32'h00000055, 1'b0, 5'd0, 5'd7, 5'd9,
          32'hA5A5A5A5, BYP ? 32'h00000055 : 32'h33334444,
          1'b0, BYP ? 1'b0 : 1'b1);
    @(posedge clk);
    #1;
    step0("post9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9,
          32'h00000033, 32'h00000055, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step0("setwr9", 1'b1, 5'd9, 32'h00000066, 1'b1, 5'd9, 5'd3, 5'd9,
          32'h00000033, BYP ? 32'h00000066 : 32'h00000055, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step0("after9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9,
          32'h0, 32'h00000066, 1'b0, 1'b1);

    // 4-port file: distinct writes to x1..x4 then a parallel read
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      b1.wr_en_in = 1'b1;
      b1.rd_addr_in = 4'(i);
      b1.rd_in = 32'h1000_0000 + 32'(i * 17);
    end
    @(posedge clk);
    #1;
    b1.wr_en_in = 1'b0;
    b1.rs_addr_in = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("mp4.p%0d", k), b1.rs_out[k*32 +: 32],
          32'h1000_0000 + 32'((k + 1) * 17));

    // reset again while clr_cnt is 10; x3 and pending x9 must clear
    drive0(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst2.ready", {31'd0, b0.ready_out}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midclr.ready", {31'd0, b0.ready_out}, 32'd0);
    release_and_count("restart");
    #1;
    chk("restart.x3", b0.rs_out[31:0], 32'd0);
    chk("restart.x9", b0.rs_out[63:32], 32'd0);
    chk("restart.p9", {31'd0, b0.rs_pend_out[1]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
